// File: rtl/booth_mult_ctrl.sv
// booth_mult_ctrl: sequences the radix-2 Booth datapath and holds its product
// behind a valid/ready result port.
module booth_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_data,
    output logic               res_err,
    output logic               busy,
    output logic [WIDTH-1:0]   dp_abus,
    output logic [WIDTH-1:0]   dp_bbus,
    output logic               dp_initP,
    output logic               dp_ldP,
    output logic               dp_ldB,
    output logic               dp_ldQ,
    output logic               dp_initQ,
    output logic               dp_ldA,
    output logic               dp_one_selB,
    output logic               dp_zero_selB,
    input  logic               dp_ao,
    input  logic               dp_qo,
    input  logic [2*WIDTH-1:0] dp_rbus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, LOAD, STEP, CAPTURE} state_t;
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic                 err_pend_q, err_pend_d;
    logic [2*WIDTH-1:0]   res_data_q, res_data_d;
    logic                 res_valid_q, res_valid_d;
    logic                 res_err_q, res_err_d;
    logic                 accept;
    assign op_ready  = (state_q == IDLE) && (!res_valid_q || res_ready);
    assign accept    = op_valid && op_ready;
    assign busy      = (state_q != IDLE);
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;
    assign dp_abus   = a_q;
    assign dp_bbus   = b_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            err_pend_q  <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            err_pend_q  <= err_pend_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            res_err_q   <= res_err_d;
        end
    end
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = accept ? op_a : a_q;
        b_d         = accept ? op_b : b_q;
        // Negating the most-negative multiplicand overflows the datapath's P register.
        err_pend_d  = accept ? (op_b == {1'b1, {(WIDTH-1){1'b0}}}) : err_pend_q;
        res_data_d  = (state_q == CAPTURE) ? dp_rbus : res_data_q;
        res_err_d   = (state_q == CAPTURE) ? err_pend_q : res_err_q;
        res_valid_d = (state_q == CAPTURE) ? 1'b1 : (res_valid_q && res_ready) ? 1'b0 : res_valid_q;
        case (state_q)
            IDLE:    state_d = accept ? LOAD : IDLE;
            LOAD: begin
                state_d = STEP;
                cnt_d   = '0;
            end
            STEP: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH-1)) ? CAPTURE : STEP;
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        dp_ldA       = (state_q == LOAD);
        dp_ldB       = (state_q == LOAD);
        dp_initP     = (state_q == LOAD);
        dp_initQ     = (state_q == LOAD);
        dp_ldP       = (state_q == STEP);
        dp_ldQ       = (state_q == STEP);
        dp_one_selB  = (state_q == STEP) && dp_ao && !dp_qo;
        dp_zero_selB = (state_q == STEP) && !dp_ao && dp_qo;
    end
endmodule
